// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store engine for an sram-like data bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    output logic              stall,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              adel,
    output logic              ades,
    output logic [ADDR_W-1:0] bad_addr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_wstrb,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic [31:0]       data_rdata,
    input  logic              data_data_ok
);

    localparam logic [2:0] c_OP_LB  = 3'd0;
    localparam logic [2:0] c_OP_LBU = 3'd1;
    localparam logic [2:0] c_OP_LH  = 3'd2;
    localparam logic [2:0] c_OP_LHU = 3'd3;
    localparam logic [2:0] c_OP_LW  = 3'd4;
    localparam logic [2:0] c_OP_SB  = 3'd5;
    localparam logic [2:0] c_OP_SH  = 3'd6;
    localparam logic [2:0] c_OP_SW  = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_cancel;
    logic [2:0]        r_op;
    logic [1:0]        r_off;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_mis;
    logic              w_idle_req;
    logic              w_accept;
    logic              w_fault;
    logic [1:0]        w_size;
    logic [3:0]        w_wstrb;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic              w_data_done;
    logic              w_capture;

    // Alignment and bus-field decode from the live MEM-stage inputs
    always_comb begin
        w_mis   = 1'b0;
        w_size  = 2'd2;
        w_wstrb = 4'b0000;
        w_wdata = mem_wdata;
        case (mem_op)
            c_OP_LB, c_OP_LBU: w_size = 2'd0;
            c_OP_LH, c_OP_LHU: begin
                w_size = 2'd1;
                w_mis  = mem_addr[0];
            end
            c_OP_LW: w_mis = (mem_addr[1:0] != 2'b00);
            c_OP_SB: begin
                w_size  = 2'd0;
                w_wstrb = 4'b0001 << mem_addr[1:0];
                w_wdata = {4{mem_wdata[7:0]}};
            end
            c_OP_SH: begin
                w_size  = 2'd1;
                w_mis   = mem_addr[0];
                w_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_wdata[15:0]}};
            end
            default: begin
                w_mis   = (mem_addr[1:0] != 2'b00);
                w_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_idle_req = resetn && (r_state == S_IDLE) && mem_valid && !flush;
    assign w_accept   = w_idle_req && !w_mis;
    assign w_fault    = w_idle_req && w_mis;

    // Load lane extraction uses the offset latched at accept time
    always_comb begin
        w_byte = data_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = data_rdata[15:8];
            2'd2:    w_byte = data_rdata[23:16];
            2'd3:    w_byte = data_rdata[31:24];
            default: w_byte = data_rdata[7:0];
        endcase
        w_half = r_off[1] ? data_rdata[31:16] : data_rdata[15:0];
        case (r_op)
            c_OP_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_ext = {24'd0, w_byte};
            c_OP_LH:  w_ext = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_ext = {16'd0, w_half};
            default:  w_ext = data_rdata;
        endcase
    end

    assign w_data_done = data_data_ok &&
                         (((r_state == S_REQ) && data_addr_ok) || (r_state == S_WAIT));
    assign w_capture   = w_data_done && !r_wr && !r_cancel && !flush;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (data_addr_ok) w_next = data_data_ok ? S_DONE : S_WAIT;
            end
            S_WAIT: if (data_data_ok) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall       = w_accept || (r_state == S_REQ) || (r_state == S_WAIT);
        data_req    = (r_state == S_REQ);
        rdata_valid = (r_state == S_DONE) && !r_wr && !r_cancel;
        adel        = w_fault && !mem_wr;
        ades        = w_fault && mem_wr;
        bad_addr    = w_fault ? mem_addr : '0;
    end

    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = r_addr;
    assign data_wstrb = r_wstrb;
    assign data_wdata = r_wdata;
    assign rdata      = r_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cancel <= 1'b0;
            r_op     <= 3'd0;
            r_off    <= 2'd0;
            r_wr     <= 1'b0;
            r_size   <= 2'd0;
            r_addr   <= '0;
            r_wstrb  <= 4'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= mem_op;
                r_off   <= mem_addr[1:0];
                r_wr    <= mem_wr;
                r_size  <= w_size;
                r_addr  <= mem_addr;
                r_wstrb <= mem_wr ? w_wstrb : 4'b0000;
                r_wdata <= w_wdata;
            end
            // A killed access still finishes on the bus; only its result is dropped
            if (((r_state == S_REQ) || (r_state == S_WAIT)) && flush) begin
                r_cancel <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_cancel <= 1'b0;
            end
            if (w_capture) begin
                r_rdata <= w_ext;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed + randomized self-checking bench for mem_access_unit
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        mem_wr;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        adel;
    logic        ades;
    logic [31:0] bad_addr;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic [31:0] data_rdata;
    logic        data_data_ok;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_rdata = 32'd0;
    bit          hold_known = 1'b1;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_op(mem_op),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
        .adel(adel), .ades(ades), .bad_addr(bad_addr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_rdata(data_rdata), .data_data_ok(data_data_ok)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_mis(input int op, input logic [31:0] a);
        if (op == 2 || op == 3 || op == 6) return (a % 2) != 0;
        if (op == 4 || op == 7) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_size(input int op);
        if (op == 0 || op == 1 || op == 5) return 0;
        if (op == 2 || op == 3 || op == 6) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] ref_wstrb(input int op, input logic [31:0] a);
        if (op == 5) return 32'd1 << (a % 4);
        if (op == 6) return ((a % 4) >= 2) ? 32'd12 : 32'd3;
        if (op == 7) return 32'd15;
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_wdata(input int op, input logic [31:0] wd);
        if (op == 5) return (wd & 32'hFF) * 32'h0101_0101;
        if (op == 6) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) & 32'hFF;
        h = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (op)
            0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            1: return b;
            2: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            3: return h;
            default: return rd;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // flush_at: index of the REQ/WAIT cycle (from 0) in which flush is pulsed; -1 for none
    task automatic access(input int op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] bus_rd, input int da, input int dd,
                          input int flush_at, input bit flush_idle);
        bit is_st, mis, cancelled;
        int cyc;
        is_st     = (op >= 5);
        mis       = ref_mis(op, a);
        cancelled = 1'b0;
        cyc       = 0;
        mem_valid = 1'b1; mem_wr = is_st; mem_op = op[2:0]; mem_addr = a; mem_wdata = wd;
        flush = flush_idle; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = bus_rd;
        #4;
        if (flush_idle || mis) begin
            check("idle_stall", stall, 0);
            check("idle_req", data_req, 0);
            check("adel", adel, (mis && !flush_idle && !is_st));
            check("ades", ades, (mis && !flush_idle && is_st));
            check("bad_addr", bad_addr, (mis && !flush_idle) ? a : 32'd0);
            next_cycle();
            mem_valid = 1'b0; flush = 1'b0;
            #4;
            check("noreq_after", data_req, 0);
            check("nostall_after", stall, 0);
            return;
        end
        check("accept_stall", stall, 1);
        check("accept_req", data_req, 0);
        check("accept_adel", adel | ades, 0);
        for (int k = 0; k <= da; k++) begin
            next_cycle();
            flush = (cyc == flush_at);
            if (flush) cancelled = 1'b1;
            data_addr_ok = (k == da);
            data_data_ok = (k == da) && (dd == 0);
            #4;
            check("req", data_req, 1);
            check("req_stall", stall, 1);
            check("req_wr", data_wr, is_st);
            check("req_size", data_size, ref_size(op));
            check("req_addr", data_addr, a);
            check("req_wstrb", data_wstrb, ref_wstrb(op, a));
            if (is_st) check("req_wdata", data_wdata, ref_wdata(op, wd));
            cyc++;
        end
        for (int j = 1; j <= dd; j++) begin
            next_cycle();
            data_addr_ok = 1'b0;
            flush = (cyc == flush_at);
            if (flush) cancelled = 1'b1;
            data_data_ok = (j == dd);
            #4;
            check("wait_req", data_req, 0);
            check("wait_stall", stall, 1);
            cyc++;
        end
        next_cycle();
        mem_valid = 1'b0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
        #4;
        check("done_stall", stall, 0);
        check("done_req", data_req, 0);
        check("rdata_valid", rdata_valid, (!is_st && !cancelled));
        if (!is_st && !cancelled) begin
            last_rdata = ref_load(op, a, bus_rd);
            hold_known = 1'b1;
            check("rdata", rdata, last_rdata);
        end else if (!is_st) begin
            hold_known = 1'b0;
        end else if (hold_known) begin
            check("rdata_hold", rdata, last_rdata);
        end
        next_cycle();
        #4;
        check("post_valid", rdata_valid, 0);
        check("post_stall", stall, 0);
    endtask

    initial begin
        resetn = 1'b0; mem_valid = 1'b0; mem_wr = 1'b0; mem_op = 3'd0; mem_addr = 32'd0;
        mem_wdata = 32'd0; flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        repeat (3) next_cycle();
        #4;
        check("rst_req", data_req, 0);
        check("rst_stall", stall, 0);
        check("rst_rdata", rdata, 0);
        check("rst_bad_addr", bad_addr, 0);
        next_cycle();
        resetn = 1'b1;

        access(0, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1, -1, 0);
        access(6, 32'h2002, 32'h0000_ABCD, 32'h0, 0, 1, -1, 0);
        access(4, 32'h3001, 32'h0, 32'h0, 0, 1, -1, 0);
        access(7, 32'h3002, 32'h1234_5678, 32'h0, 0, 1, -1, 0);
        access(5, 32'h3001, 32'h0000_005A, 32'h0, 4, 2, -1, 0);
        access(4, 32'h3100, 32'h0, 32'hCAFE_F00D, 2, 0, -1, 0);
        access(3, 32'h4002, 32'h0, 32'h9ABC_0000, 0, 1, -1, 0);
        access(2, 32'h4002, 32'h0, 32'h9ABC_0000, 1, 1, -1, 0);
        access(4, 32'h5000, 32'h0, 32'h1111_2222, 0, 2, 1, 0);
        access(4, 32'h5004, 32'h0, 32'h3333_4444, 0, 1, -1, 0);
        access(4, 32'h5008, 32'h0, 32'h0, 0, 1, -1, 1);

        // Reset in the middle of a pending request
        mem_valid = 1'b1; mem_wr = 1'b1; mem_op = 3'd7; mem_addr = 32'h6004; mem_wdata = 32'hDEAD_BEEF;
        next_cycle();
        #4;
        check("mid_req", data_req, 1);
        next_cycle();
        resetn = 1'b0; mem_valid = 1'b0;
        next_cycle();
        resetn = 1'b1;
        #4;
        check("mrst_req", data_req, 0);
        check("mrst_stall", stall, 0);
        check("mrst_rdata", rdata, 0);
        check("mrst_wdata", data_wdata, 0);
        check("mrst_addr", data_addr, 0);
        check("mrst_wstrb", data_wstrb, 0);
        check("mrst_misc", {data_wr, data_size, rdata_valid, adel, ades}, 0);
        check("mrst_bad", bad_addr, 0);
        last_rdata = 32'd0;
        hold_known = 1'b1;

        for (int i = 0; i < 300; i++) begin
            int op, da, dd, fa;
            logic [31:0] a;
            op = $urandom_range(0, 7);
            a  = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = (op == 4 || op == 7) ? 2'b00 : {a[1], 1'b0};
            da = $urandom_range(0, 4);
            dd = $urandom_range(0, 3);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, da + dd) : -1;
            access(op, a, $urandom, $urandom, da, dd, fa, ($urandom_range(0, 9) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the data-memory access for the load/store that the main decoder flags with memen/memwrite.
- Sits in the MEM stage between the pipeline and the data-side sram-like bus.
- Generates size, byte strobes and lane-replicated store data, and sign/zero-extends load data.
- Raises address-error exceptions for misaligned accesses and stalls the pipeline until the bus completes.

Parameters:
ADDR_W, 32, width of the byte address on pipeline and bus sides

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
mem_valid  input  1  MEM-stage instruction valid and memen=1
mem_wr  input  1  1=store (memwrite), 0=load
mem_op  input  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
mem_addr  input  ADDR_W  effective byte address
mem_wdata  input  32  rt value for stores
flush  input  1  exception/redirect kill of the MEM-stage instruction
stall  output  1  hold pipeline
rdata  output  32  extended load result
rdata_valid  output  1  one-cycle pulse, rdata usable
adel  output  1  load misalignment
ades  output  1  store misalignment
bad_addr  output  ADDR_W  faulting address
data_req  output  1  bus request
data_wr  output  1  bus write
data_size  output  2  0 byte, 1 half, 2 word
data_addr  output  ADDR_W  bus byte address
data_wstrb  output  4  byte enables
data_wdata  output  32  lane-replicated store data
data_addr_ok  input  1  request accepted
data_rdata  input  32  read data
data_data_ok  input  1  data phase done

Behaviour:
- Clock and reset: clk; resetn is synchronous and active-low. Reset forces state IDLE and clears the cancel flag and latched op/offset.
- Reset values: all outputs 0, including rdata and bad_addr.
- States: IDLE, REQ, WAIT, DONE.
- Misalignment:
  - mis = (op in LH/LHU/SH and addr[0]) or (op in LW/SW and addr[1:0]!=0).
  - Byte ops are never misaligned.
- IDLE:
  - If mem_valid & mis & !flush: adel=!mem_wr, ades=mem_wr, bad_addr=mem_addr, combinationally in the same cycle.
  - In that case there is no bus request, stall=0 and the state stays IDLE.
  - If mem_valid & !mis & !flush: latch op, addr[1:0] and bus fields; go to REQ; stall=1 combinationally this cycle.
- REQ:
  - data_req=1 with registered wr/size/addr/wstrb/wdata, held stable until data_addr_ok.
  - On data_addr_ok go to WAIT.
  - If data_addr_ok and data_data_ok arrive in the same cycle, go straight to DONE.
  - stall=1.
- WAIT:
  - data_req=0; on data_data_ok capture the extended data_rdata and go to DONE.
  - stall=1.
- DONE:
  - stall=0; rdata_valid=1 for loads only when not cancelled; next state IDLE.
  - rdata holds its value until the next load completes.
- Flush:
  - In IDLE, the request is suppressed and no exception is raised.
  - In REQ or WAIT, set cancel. The request stays asserted until addr_ok because bus protocol forbids withdrawal.
  - The outstanding transaction completes; in DONE rdata_valid is suppressed; cancel clears on entering IDLE.
  - stall stays 1 until DONE regardless of flush.
- Bus fields:
  - size: byte ops 0, half ops 1, word ops 2.
  - wstrb:
    - Loads: 0000.
    - SB: 0001<<addr[1:0].
    - SH: 0011 if addr[1]=0, else 1100.
    - SW: 1111.
  - wdata: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}, SW wdata.
  - data_addr: full mem_addr, unmodified.
- Load extract (latched offset o):
  - Byte = data_rdata[8o+7:8o]; LB sign-extends it, LBU zero-extends it.
  - Half = data_rdata[16*o[1]+15:16*o[1]]; LH sign-extends it, LHU zero-extends it.
  - LW passes data_rdata through.
- Latency: with addr_ok and data_ok each one cycle after asserting, the access takes 3 stall cycles, then DONE.
- Reset mid-transaction: returns to IDLE next edge and deasserts data_req. Bus recovery is the bus's responsibility since the bus shares the reset.

Test Plan:
- LB at addr 0x1003, data_rdata=0x80FF_1234 -> data_size=0, wstrb=0000, rdata=0xFFFF_FF80, one rdata_valid pulse, stall high exactly REQ+WAIT cycles.
- SH at 0x2002 with wdata=0x0000_ABCD -> data_wdata=0xABCD_ABCD, wstrb=1100, size=1, data_wr=1, no rdata_valid.
- LW at 0x3001 -> adel=1, bad_addr=0x3001, data_req never asserted, stall=0; SW at 0x3002 -> ades=1.
- addr_ok delayed 4 cycles -> data_req/addr/wstrb stable all 4 cycles; same-cycle addr_ok+data_ok -> REQ->DONE directly; LHU at 0x4002 with rdata=0x9ABC_0000 -> 0x0000_9ABC.
- Flush asserted in WAIT of LW -> transaction completes on data_ok, rdata_valid stays 0, next load issues normally.
- resetn=0 during REQ -> next cycle data_req=0, stall=0, all outputs 0, state IDLE.
